// File: rtl/trace_stream_capture.sv
// trace_stream_capture
//
// Cycle-stamped AXI-Stream monitor. It passively taps one stream port and
// stamps every handshaked beat with the free-running cycle count. The records
// are buffered in a first-word-fall-through FIFO and presented on a
// valid/ready record port.
//
// Optional feature macro: TRACE_OVF_MARKER_EN
//   When defined, beats lost to overflow are summarised by a marker record
//   (kind=1) that is pushed at the first opportunity. Until that marker is
//   pushed, new beats are dropped. When undefined, drops are only counted
//   in drop_total.
//
// Ports:
//   clk, rst       single clock, asynchronous active-high reset
//   en             capture enable (gates new captures only)
//   mon_tvalid/mon_tready/mon_tdata/mon_tlast   tapped stream
//   rec_valid/rec_ready/rec_data                record output {kind,last,ts,payload}
//   clkcnt         free-running cycle counter
//   fifo_level     number of buffered records
//   drop_total     saturating lifetime count of dropped beats

module trace_stream_capture #(
  parameter int DATA_W = 32,
  parameter int TS_W   = 48,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       mon_tvalid,
  input  logic                       mon_tready,
  input  logic [DATA_W-1:0]          mon_tdata,
  input  logic                       mon_tlast,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [2+TS_W+DATA_W-1:0]   rec_data,
  output logic [TS_W-1:0]            clkcnt,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [31:0]                drop_total
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int REC_W = 2 + TS_W + DATA_W;

  logic [TS_W-1:0]  clkcnt_q;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [LW-1:0]    level_q, level_d;
  logic [31:0]      dropTotal_q;

  logic             popEn;
  logic             pushSpace;
  logic             capture;
  logic             pushEn;
  logic             dropEn;
  logic [REC_W-1:0] beatRec;
  logic [REC_W-1:0] pushRec;

  // Push space also counts a same-cycle pop, so a full FIFO keeps streaming.
  assign popEn     = (level_q != '0) && rec_ready;
  assign pushSpace = (level_q != LW'(DEPTH)) || popEn;
  assign capture   = en && mon_tvalid && mon_tready;
  assign beatRec   = {1'b0, mon_tlast, clkcnt_q, mon_tdata};

`ifdef TRACE_OVF_MARKER_EN
  logic [CNT_W-1:0] dropPending_q, dropPending_d;
  logic [CNT_W-1:0] pendingInc;
  logic [CNT_W-1:0] markerCount;
  logic             pending;

  // While losses are outstanding the push slot belongs to the marker, so
  // any beat seen in that window is dropped and folded into the count.
  always_comb begin
    pending       = (dropPending_q != '0);
    pendingInc    = (dropPending_q == '1) ? dropPending_q : dropPending_q + 1'b1;
    markerCount   = capture ? pendingInc : dropPending_q;
    pushEn        = pushSpace && (pending || capture);
    dropEn        = capture && (pending || !pushSpace);
    pushRec       = pending ? {1'b1, 1'b0, clkcnt_q, DATA_W'(markerCount)} : beatRec;
    dropPending_d = dropPending_q;
    if (pending && pushSpace) begin
      dropPending_d = '0;
    end else if (dropEn) begin
      dropPending_d = pendingInc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropPending_q <= '0;
    end else begin
      dropPending_q <= dropPending_d;
    end
  end
`else
  always_comb begin
    pushEn  = capture && pushSpace;
    dropEn  = capture && !pushSpace;
    pushRec = beatRec;
  end
`endif

  always_comb begin
    level_d = level_q;
    if (pushEn && !popEn) begin
      level_d = level_q + 1'b1;
    end else if (popEn && !pushEn) begin
      level_d = level_q - 1'b1;
    end
  end

  // Control state; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkcnt_q    <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      dropTotal_q <= '0;
    end else begin
      clkcnt_q <= clkcnt_q + 1'b1;
      level_q  <= level_d;
      if (pushEn) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (popEn) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      if (dropEn && (dropTotal_q != '1)) begin
        dropTotal_q <= dropTotal_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible once counted in level_q.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem_q[wrPtr_q] <= pushRec;
    end
  end

  assign rec_valid  = (level_q != '0);
  assign rec_data   = rec_valid ? mem_q[rdPtr_q] : '0;
  assign clkcnt     = clkcnt_q;
  assign fifo_level = level_q;
  assign drop_total = dropTotal_q;

endmodule

// File: tb/tb_trace_stream_capture.sv
// tb_trace_stream_capture
//
// Directed testbench for trace_stream_capture. The main instance uses the
// default parameters. A second instance with TS_W=8 and DEPTH=4 shares the
// same stimulus and is used to observe timestamp wrap-around.

module tb_trace_stream_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mon_tvalid;
  logic        mon_tready;
  logic [31:0] mon_tdata;
  logic        mon_tlast;
  logic        rec_ready;

  logic        rec_valid;
  logic [81:0] rec_data;
  logic [47:0] clkcnt;
  logic [4:0]  fifo_level;
  logic [31:0] drop_total;

  logic        recValidS;
  logic [41:0] recDataS;
  logic [7:0]  clkcntS;
  logic [2:0]  levelS;
  logic [31:0] dropS;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  trace_stream_capture dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mon_tvalid (mon_tvalid),
    .mon_tready (mon_tready),
    .mon_tdata  (mon_tdata),
    .mon_tlast  (mon_tlast),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_data   (rec_data),
    .clkcnt     (clkcnt),
    .fifo_level (fifo_level),
    .drop_total (drop_total)
  );

  trace_stream_capture #(.DATA_W(32), .TS_W(8), .DEPTH(4), .CNT_W(16)) dutSmall (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mon_tvalid (mon_tvalid),
    .mon_tready (mon_tready),
    .mon_tdata  (mon_tdata),
    .mon_tlast  (mon_tlast),
    .rec_valid  (recValidS),
    .rec_ready  (rec_ready),
    .rec_data   (recDataS),
    .clkcnt     (clkcntS),
    .fifo_level (levelS),
    .drop_total (dropS)
  );

  // Holds reset over the start of simulation and checks reset values.
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
    mon_tdata = '0; mon_tlast = 1'b0; rec_ready = 1'b0;
    @(negedge clk);
    compared++;
    if (clkcnt !== 48'd0) begin
      mismatched++; $display("[TB] FAIL reset_clkcnt: got %0d expected 0", clkcnt);
    end
    compared++;
    if (rec_valid !== 1'b0 || fifo_level !== 5'd0) begin
      mismatched++; $display("[TB] FAIL reset_fifo: got valid=%0b level=%0d expected 0/0", rec_valid, fifo_level);
    end
    compared++;
    if (rec_data !== 82'd0 || drop_total !== 32'd0) begin
      mismatched++; $display("[TB] FAIL reset_data: got data=%0h drops=%0d expected 0/0", rec_data, drop_total);
    end
    rst = 1'b0;
  endtask

  // One beat handshaked while clkcnt=10 must appear one cycle later with ts=10.
  task automatic test_single_beat();
    int guard = 0;
    en = 1'b1;
    while (clkcnt != 48'd10 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    compared++;
    if (clkcnt !== 48'd10) begin
      mismatched++; $display("[TB] FAIL single_wait: got clkcnt=%0d expected 10", clkcnt);
    end
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tdata = 32'hA5A5_0001; mon_tlast = 1'b1;
    @(negedge clk);
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    compared++;
    if (rec_valid !== 1'b1 || fifo_level !== 5'd1) begin
      mismatched++; $display("[TB] FAIL single_level: got valid=%0b level=%0d expected 1/1", rec_valid, fifo_level);
    end
    compared++;
    if (rec_data !== {2'b01, 48'd10, 32'hA5A5_0001}) begin
      mismatched++; $display("[TB] FAIL single_record: got %0h expected %0h", rec_data, {2'b01, 48'd10, 32'hA5A5_0001});
    end
    rec_ready = 1'b1;
    @(negedge clk);
    rec_ready = 1'b0;
    compared++;
    if (rec_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL single_pop: got valid=%0b expected 0", rec_valid);
    end
  endtask

  // 20 beats into a 16-deep FIFO with no consumer, then drain.
  task automatic test_overflow();
    logic [47:0] markTs;
    rec_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mon_tvalid = 1'b1; mon_tready = 1'b1;
      mon_tdata = 32'h100 + i; mon_tlast = (i == 19);
      @(negedge clk);
    end
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    compared++;
    if (fifo_level !== 5'd16) begin
      mismatched++; $display("[TB] FAIL ovf_level: got %0d expected 16", fifo_level);
    end
    compared++;
    if (drop_total !== 32'd4) begin
      mismatched++; $display("[TB] FAIL ovf_drops: got %0d expected 4", drop_total);
    end
    rec_ready = 1'b1;
    markTs = clkcnt;
    for (int j = 0; j < 16; j++) begin
      compared++;
      if (rec_valid !== 1'b1 || rec_data[81:80] !== 2'b00 || rec_data[31:0] !== 32'h100 + j) begin
        mismatched++; $display("[TB] FAIL ovf_beat%0d: got valid=%0b data=%0h expected payload %0h", j, rec_valid, rec_data, 32'h100 + j);
      end
      @(negedge clk);
    end
`ifdef TRACE_OVF_MARKER_EN
    compared++;
    if (rec_valid !== 1'b1 || rec_data !== {2'b10, markTs, 32'd4}) begin
      mismatched++; $display("[TB] FAIL ovf_marker: got valid=%0b data=%0h expected %0h", rec_valid, rec_data, {2'b10, markTs, 32'd4});
    end
    @(negedge clk);
`endif
    compared++;
    if (rec_valid !== 1'b0 || fifo_level !== 5'd0) begin
      mismatched++; $display("[TB] FAIL ovf_drained: got valid=%0b level=%0d expected 0/0", rec_valid, fifo_level);
    end
    rec_ready = 1'b0;
  endtask

  // No capture with en=0, nor without tready; clkcnt keeps running.
  task automatic test_enable_gating();
    logic [47:0] startCnt;
    startCnt = clkcnt;
    en = 1'b0; mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tdata = 32'hDEAD_0000;
    repeat (3) @(negedge clk);
    en = 1'b1; mon_tready = 1'b0;
    repeat (3) @(negedge clk);
    mon_tvalid = 1'b0;
    compared++;
    if (rec_valid !== 1'b0 || fifo_level !== 5'd0) begin
      mismatched++; $display("[TB] FAIL gate_noRecord: got valid=%0b level=%0d expected 0/0", rec_valid, fifo_level);
    end
    compared++;
    if (clkcnt !== startCnt + 48'd6) begin
      mismatched++; $display("[TB] FAIL gate_clkcnt: got %0d expected %0d", clkcnt, startCnt + 48'd6);
    end
  endtask

  // Reset pulse with five records buffered and drops outstanding.
  task automatic test_reset_midop();
    rec_ready = 1'b0; en = 1'b1; mon_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mon_tvalid = 1'b1; mon_tdata = 32'h300 + i;
      @(negedge clk);
    end
    mon_tvalid = 1'b0;
    compared++;
    if (fifo_level !== 5'd5 || drop_total !== 32'd4) begin
      mismatched++; $display("[TB] FAIL midop_pre: got level=%0d drops=%0d expected 5/4", fifo_level, drop_total);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (rec_valid !== 1'b0 || fifo_level !== 5'd0 || drop_total !== 32'd0 || rec_data !== 82'd0) begin
      mismatched++; $display("[TB] FAIL midop_async: got valid=%0b level=%0d drops=%0d data=%0h expected all 0", rec_valid, fifo_level, drop_total, rec_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (clkcnt !== 48'd1) begin
      mismatched++; $display("[TB] FAIL midop_clkcnt: got %0d expected 1", clkcnt);
    end
  endtask

  // Full FIFO with a simultaneous pop and beat capture.
  task automatic test_back_to_back();
    rec_ready = 1'b0; en = 1'b1; mon_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mon_tvalid = 1'b1; mon_tdata = 32'h200 + i;
      @(negedge clk);
    end
    compared++;
    if (fifo_level !== 5'd16 || rec_data[31:0] !== 32'h200) begin
      mismatched++; $display("[TB] FAIL b2b_full: got level=%0d head=%0h expected 16/200", fifo_level, rec_data[31:0]);
    end
    rec_ready = 1'b1; mon_tdata = 32'h2FF;
    @(negedge clk);
    rec_ready = 1'b0; mon_tvalid = 1'b0;
    compared++;
    if (fifo_level !== 5'd16 || drop_total !== 32'd0) begin
      mismatched++; $display("[TB] FAIL b2b_level: got level=%0d drops=%0d expected 16/0", fifo_level, drop_total);
    end
    compared++;
    if (rec_data[31:0] !== 32'h201) begin
      mismatched++; $display("[TB] FAIL b2b_head: got %0h expected 201", rec_data[31:0]);
    end
  endtask

  // Timestamp wrap on the 8-bit-counter instance.
  task automatic test_wrap();
    int guard = 0;
    mon_tvalid = 1'b0; rec_ready = 1'b0; en = 1'b1; mon_tready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    while (clkcntS != 8'd255 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    compared++;
    if (clkcntS !== 8'd255) begin
      mismatched++; $display("[TB] FAIL wrap_wait: got clkcnt=%0d expected 255", clkcntS);
    end
    mon_tvalid = 1'b1; mon_tdata = 32'h0000_00AA;
    @(negedge clk);
    mon_tdata = 32'h0000_00BB;
    @(negedge clk);
    mon_tvalid = 1'b0;
    compared++;
    if (levelS !== 3'd2 || recDataS !== {2'b00, 8'd255, 32'h0000_00AA}) begin
      mismatched++; $display("[TB] FAIL wrap_ts255: got level=%0d data=%0h expected 2/%0h", levelS, recDataS, {2'b00, 8'd255, 32'h0000_00AA});
    end
    rec_ready = 1'b1;
    @(negedge clk);
    rec_ready = 1'b0;
    compared++;
    if (recValidS !== 1'b1 || recDataS !== {2'b00, 8'd0, 32'h0000_00BB}) begin
      mismatched++; $display("[TB] FAIL wrap_ts0: got valid=%0b data=%0h expected %0h", recValidS, recDataS, {2'b00, 8'd0, 32'h0000_00BB});
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_overflow();
    test_enable_gating();
    test_reset_midop();
    test_back_to_back();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trace_stream_capture.md
# trace_stream_capture

Cycle-stamped AXI-Stream monitor for the hwemu trace agent. Sits directly downstream of the clock/reset trace interface. Counts cycles of the same clk/rst pair that interface records or replays. Passively taps one stream port, stamps every handshaked beat with the cycle count, buffers the records, and presents them on a valid/ready record port to the trace file writer.

## Interface
Parameters:
- DATA_W, 32, monitored tdata width
- TS_W, 48, timestamp/cycle-counter width
- DEPTH, 16, record FIFO entries (power of two, ≥2)
- CNT_W, 16, pending-drop counter width

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  reset, asynchronous, active-high
- en  in  1  capture enable
- mon_tvalid  in  1  tapped stream valid
- mon_tready  in  1  tapped stream ready
- mon_tdata  in  DATA_W  tapped stream data
- mon_tlast  in  1  tapped stream last
- rec_valid  out  1  record available
- rec_ready  in  1  record consumer ready
- rec_data  out  2+TS_W+DATA_W  record: {kind, last, ts[TS_W-1:0], payload[DATA_W-1:0]}
- clkcnt  out  TS_W  free-running cycle count
- fifo_level  out  $clog2(DEPTH)+1  current record count
- drop_total  out  32  lifetime dropped beats, saturating

## Operation
- Reset values:
  - clkcnt=0, fifo_level=0, rec_valid=0, drop_total=0.
  - rec_data=0; FIFO contents do not matter.
  - Internal drop_pending=0.
- clkcnt increments by 1 every clk edge while rst=0, independent of en. Wraps modulo 2^TS_W.
- Capture condition: en & mon_tvalid & mon_tready, sampled at a clk edge.
- Beat record format:
  - kind=0, last=mon_tlast.
  - ts=clkcnt value before that edge, i.e. the cycle in which the handshake was visible.
  - payload=mon_tdata.
- Push space exists when fifo_level<DEPTH, or a pop (rec_valid & rec_ready) occurs in the same cycle.
- A beat is dropped when it is captured with no space available, or while drop_pending≠0 (overflow marker mode).
  - On each drop: drop_pending++ (saturates at 2^CNT_W−1) and drop_total++ (saturates at 2^32−1).
- FIFO is first-word-fall-through:
  - rec_valid = (fifo_level≠0).
  - rec_data = head entry.
  - Pop on rec_valid & rec_ready.
- en=0 stops new captures only. Buffered records and pending markers still drain.

## Timing
- Capture latency: a beat captured at edge N into an empty FIFO gives rec_valid=1 after edge N, with its record on rec_data.
- Throughput: one record per cycle in and one out.
- Full FIFO with a same-cycle push and pop: both occur and fifo_level is unchanged.
- Records leave in capture order. Markers are ordered relative to beats exactly at the point of loss.
- rec_data stays stable while rec_valid=1 and rec_ready=0.
- Reset mid-operation: all state clears asynchronously and buffered records are discarded. clkcnt restarts from 0 on the first edge after rst deasserts.

## Configuration
- TRACE_OVF_MARKER_EN defined:
  - When drop_pending≠0, a marker record is pushed in the first cycle with push space.
  - Marker fields: kind=1, last=0, ts=current clkcnt, payload=zero-extended drop_pending.
  - A beat captured in the marker's push cycle is also dropped and counted into that marker (payload = drop_pending+1, saturating).
  - drop_pending clears in the marker's push cycle.
  - Beats resume from the next cycle.
- Undefined:
  - No markers; kind is always 0.
  - Drops only increment drop_total; drop_pending logic is absent.
  - A beat is captured whenever push space exists.

## Test plan
- Reset release, en=1, single beat (tdata=0xA5A5_0001, tlast=1) handshaked in the cycle where clkcnt=10 → one cycle later rec_valid=1, rec_data={0,1,48'd10,0xA5A5_0001}, fifo_level=1.
- rec_ready=0, 20 back-to-back beats into DEPTH=16 → fifo_level=16, drop_total=4.
  - With the macro: after rec_ready=1, 16 beat records, then a marker with payload=4 (plus any beats dropped while the marker waited).
  - Without the macro: exactly 16 records.
- Full FIFO, rec_ready=1 and a beat captured in the same cycle → both pop and push occur, fifo_level stays 16, drop_total unchanged.
- Handshake with en=0, and mon_tvalid=1 with mon_tready=0 → no record, fifo_level=0, clkcnt still advancing.
- Preload clkcnt near wrap (force TS_W=8), capture at clkcnt=255 and the next cycle → ts=255, then ts=0.
- Assert rst for 1 cycle with 5 records buffered → rec_valid=0, fifo_level=0, drop_total=0 immediately. clkcnt=1 after the first edge post-deassertion.
